// File: rtl/shot_tracker_pkg.sv
// Shared definitions for the shot tracker: FSM state encoding, display
// select codes, board geometry, result pulse encoding and a popcount helper.
package shot_tracker_pkg;

   typedef enum logic [1:0] {
      ST_SETUP = 2'd0,
      ST_PLAY  = 2'd1,
      ST_WIN   = 2'd2,
      ST_LOSE  = 2'd3
   } state_t;

   localparam logic [1:0] SHOW_BOARD = 2'b01;
   localparam logic [1:0] SHOW_HITS  = 2'b10;

   localparam int NUM_COLS  = 5;
   localparam int NUM_ROWS  = 7;
   localparam int NUM_CELLS = NUM_COLS * NUM_ROWS;

   // Result pulse vector ordering: {hit, miss, again, invalid}
   localparam logic [3:0] RES_HIT     = 4'b1000;
   localparam logic [3:0] RES_MISS    = 4'b0100;
   localparam logic [3:0] RES_AGAIN   = 4'b0010;
   localparam logic [3:0] RES_INVALID = 4'b0001;

   function automatic logic [5:0] popcount(input logic [NUM_CELLS-1:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         n = n + {5'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/shot_tracker_if.sv
// Shot tracker bus: player inputs (ship map, lock, fire, target, new_game)
// and game outputs (display select, hit map, result pulses, counters,
// game status).
//   master : drives the player inputs, observes the game outputs
//   slave  : the tracker itself
interface shot_tracker_if;
   import shot_tracker_pkg::*;

   logic [NUM_ROWS-1:0] col1, col2, col3, col4, col5;
   logic                lock;
   logic                fire;
   logic [2:0]          sel_col;
   logic [2:0]          sel_row;
   logic                new_game;

   logic [1:0]          show;
   logic [NUM_ROWS-1:0] colHit1, colHit2, colHit3, colHit4, colHit5;
   logic                hit, miss, again, invalid;
   logic [5:0]          hits_count;
   logic [4:0]          shots_left;
   logic                game_over;
   logic                win;

   modport master (
      output col1, col2, col3, col4, col5, lock, fire, sel_col, sel_row, new_game,
      input  show, colHit1, colHit2, colHit3, colHit4, colHit5,
             hit, miss, again, invalid, hits_count, shots_left, game_over, win
   );

   modport slave (
      input  col1, col2, col3, col4, col5, lock, fire, sel_col, sel_row, new_game,
      output show, colHit1, colHit2, colHit3, colHit4, colHit5,
             hit, miss, again, invalid, hits_count, shots_left, game_over, win
   );

endinterface

// File: rtl/shot_tracker_button_pulse.sv
// button_pulse: debounces a level button and emits a one-cycle pulse in the
// same cycle the (filtered) input is first seen high. A held button yields a
// single pulse.
//   clk, reset : clock and synchronous active-high reset
//   din        : raw button level
//   pulse      : one-cycle rising-edge pulse of the filtered level
module button_pulse #(
   parameter int DEBOUNCE_CYC = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic filt_q;
   logic stable;

   generate
      if (DEBOUNCE_CYC == 0) begin : g_nofilt
         assign stable = 1'b1;
      end else begin : g_filt
         localparam int CW = $clog2(DEBOUNCE_CYC + 1);
         localparam logic [CW-1:0] DC = CW'(DEBOUNCE_CYC);

         logic          din_q;
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] run_len;
         logic [CW-1:0] cnt_nx;

         // run_len: earlier consecutive cycles that already carried the
         // current value; the level counts once it has held DC cycles.
         always_comb begin
            run_len = (din == din_q) ? cnt_q : '0;
            cnt_nx  = (run_len >= DC) ? DC : run_len + 1'b1;
         end

         assign stable = (run_len >= DC);

         always_ff @(posedge clk) begin
            if (reset) begin
               din_q <= 1'b0;
               cnt_q <= '0;
            end else begin
               din_q <= din;
               cnt_q <= cnt_nx;
            end
         end
      end
   endgenerate

   assign pulse = din & ~filt_q & stable;

   always_ff @(posedge clk) begin
      if (reset) begin
         filt_q <= 1'b0;
      end else if (stable) begin
         filt_q <= din;
      end
   end

endmodule

// File: rtl/shot_tracker.sv
// shot_tracker: two-player battleship scorer. Player 1 locks a 5x7 ship map,
// player 2 fires at cells; the block tracks shot and hit maps, hit/shot
// counters and the SETUP/PLAY/WIN/LOSE game state.
//   clk, reset : clock and synchronous active-high reset
//   bus        : shot_tracker_if slave (player inputs, display/result outputs)
module shot_tracker
   import shot_tracker_pkg::*;
#(
   parameter int MAX_SHOTS    = 20,
   parameter int DEBOUNCE_CYC = 0
) (
   input  logic           clk,
   input  logic           reset,
   shot_tracker_if.slave  bus
);

   localparam logic [4:0] MAX_W = 5'(MAX_SHOTS);

   state_t                 state_q, state_nx;
   logic [NUM_CELLS-1:0]   board_q, board_nx;
   logic [NUM_CELLS-1:0]   shot_q,  shot_nx;
   logic [NUM_CELLS-1:0]   hmap_q,  hmap_nx;
   logic [5:0]             total_q, total_nx;
   logic [5:0]             hits_q,  hits_nx;
   logic [4:0]             left_q,  left_nx;
   logic [3:0]             res_p1,  res_nx;

   logic [NUM_CELLS-1:0]   cols_in;
   logic [5:0]             cols_pop;
   logic [5:0]             cell_idx;
   logic                   cell_ok;
   logic                   shot_vld_p0;

   button_pulse #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_fire (
      .clk   (clk),
      .reset (reset),
      .din   (bus.fire),
      .pulse (shot_vld_p0)
   );

   // Column c occupies bits [c*7 +: 7], row r is bit r within the column.
   assign cols_in  = {bus.col5, bus.col4, bus.col3, bus.col2, bus.col1};
   assign cols_pop = popcount(cols_in);
   assign cell_ok  = (bus.sel_col < 3'd5) && (bus.sel_row < 3'd7);
   assign cell_idx = ({3'b0, bus.sel_col} * 6'd7) + {3'b0, bus.sel_row};

   // Stage p0: qualifying fire edge, shot resolution and next game state
   always_comb begin
      state_nx = state_q;
      board_nx = board_q;
      shot_nx  = shot_q;
      hmap_nx  = hmap_q;
      total_nx = total_q;
      hits_nx  = hits_q;
      left_nx  = left_q;
      res_nx   = '0;

      case (state_q)
         ST_SETUP: begin
            if (bus.lock && (cols_pop != 6'd0)) begin
               board_nx = cols_in;
               total_nx = cols_pop;
               shot_nx  = '0;
               hmap_nx  = '0;
               hits_nx  = '0;
               left_nx  = MAX_W;
               state_nx = ST_PLAY;
            end
         end

         ST_PLAY: begin
            if (shot_vld_p0) begin
               if (!cell_ok) begin
                  res_nx = RES_INVALID;
               end else if (shot_q[cell_idx]) begin
                  res_nx = RES_AGAIN;
               end else begin
                  shot_nx[cell_idx] = 1'b1;
                  if (board_q[cell_idx]) begin
                     hmap_nx[cell_idx] = 1'b1;
                     if (hits_q < total_q) hits_nx = hits_q + 6'd1;
                     res_nx = RES_HIT;
                  end else begin
                     res_nx = RES_MISS;
                  end
                  if (left_q != 5'd0) left_nx = left_q - 5'd1;
                  // A last shot that sinks the last ship cell is a win.
                  if (hits_nx == total_q)    state_nx = ST_WIN;
                  else if (left_nx == 5'd0)  state_nx = ST_LOSE;
               end
            end
         end

         ST_WIN, ST_LOSE: begin
            if (bus.new_game) begin
               state_nx = ST_SETUP;
               hmap_nx  = '0;
               hits_nx  = '0;
            end
         end

         default: state_nx = ST_SETUP;
      endcase
   end

   // Stage p1: registered game state and result pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_SETUP;
         board_q <= '0;
         shot_q  <= '0;
         hmap_q  <= '0;
         total_q <= '0;
         hits_q  <= '0;
         left_q  <= MAX_W;
         res_p1  <= '0;
      end else begin
         state_q <= state_nx;
         board_q <= board_nx;
         shot_q  <= shot_nx;
         hmap_q  <= hmap_nx;
         total_q <= total_nx;
         hits_q  <= hits_nx;
         left_q  <= left_nx;
         res_p1  <= res_nx;
      end
   end

   assign bus.show       = (state_q == ST_SETUP) ? SHOW_BOARD : SHOW_HITS;
   assign bus.colHit1    = hmap_q[0*NUM_ROWS +: NUM_ROWS];
   assign bus.colHit2    = hmap_q[1*NUM_ROWS +: NUM_ROWS];
   assign bus.colHit3    = hmap_q[2*NUM_ROWS +: NUM_ROWS];
   assign bus.colHit4    = hmap_q[3*NUM_ROWS +: NUM_ROWS];
   assign bus.colHit5    = hmap_q[4*NUM_ROWS +: NUM_ROWS];
   assign bus.hit        = res_p1[3];
   assign bus.miss       = res_p1[2];
   assign bus.again      = res_p1[1];
   assign bus.invalid    = res_p1[0];
   assign bus.hits_count = hits_q;
   assign bus.shots_left = left_q;
   assign bus.game_over  = (state_q == ST_WIN) || (state_q == ST_LOSE);
   assign bus.win        = (state_q == ST_WIN);

endmodule
